pll_reset_sequencer: RTL and testbench

Reset and lock sequencer for the iCE40 SB_PLL40_CORE clock generator. It holds the PLL in reset after power-up and drives its active-low RESETB. It synchronises and qualifies the asynchronous PLL LOCK output, then releases the core-logic reset only after lock has been stable. It retries on lock timeout, re-sequences on lock loss and reports a hard fault after repeated failures. It runs on the board reference clock, never on the PLL output.

---
 rtl/pll_reset_sequencer.sv | 118 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Power-up reset and lock qualification for an iCE40 PLL, clocked from the board reference.
// Holds the PLL in reset, waits for a stable LOCK, then releases core reset; retries and faults on failure.
module pll_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 10000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_WIDTH           = 16
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       SOFT_RESTART,
  output logic       PLL_RESETB,
  output logic       CORE_RESETN,
  output logic       READY,
  output logic       FAULT,
  output logic [1:0] RETRY_COUNT,
  output logic [7:0] LOCK_LOSS_COUNT
);

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]           RETRY_MAX    = 2'(MAX_RETRIES);

  logic                 sync1_q, lock_s_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           retry_q, retry_d;
  logic [7:0]           loss_q, loss_d;
  logic                 pll_resetb_q, core_resetn_q, ready_q, fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (SOFT_RESTART) begin
      state_d = S_HOLD;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = S_HOLD;
            end else begin
              state_d = S_FAULT;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q)                 state_d = S_WAIT;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_HOLD;
            retry_d = 2'd0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_HOLD;
      endcase
    end
    // A restart re-arms the hold window even when already in HOLD.
    if (SOFT_RESTART || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      retry_q       <= 2'd0;
      loss_q        <= 8'd0;
      pll_resetb_q  <= 1'b0;
      core_resetn_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      sync1_q       <= PLL_LOCK;
      lock_s_q      <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      // Outputs decode the next state so they switch on the same edge as the state register.
      pll_resetb_q  <= (state_d == S_WAIT) || (state_d == S_STABLE) || (state_d == S_RUN);
      core_resetn_q <= (state_d == S_RUN);
      ready_q       <= (state_d == S_RUN);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign PLL_RESETB      = pll_resetb_q;
  assign CORE_RESETN     = core_resetn_q;
  assign READY           = ready_q;
  assign FAULT           = fault_q;
  assign RETRY_COUNT     = retry_q;
  assign LOCK_LOSS_COUNT = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, directed corner sequences,
// and random lock/restart traffic against a dwell-time reference model.
module tb_pll_reset_sequencer;

  localparam int HOLD_N = 4;
  localparam int TO_N   = 20;
  localparam int ST_N   = 8;
  localparam int MAXR   = 2;

  logic       clk, rst_n, lock_r, soft_r;
  logic       pll_resetb, core_resetn, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;
  logic [13:0] dut_vec;

  int ntests = 0;
  int nfail  = 0;

  pll_reset_sequencer #(
    .RESET_HOLD_CYCLES  (HOLD_N),
    .LOCK_TIMEOUT_CYCLES(TO_N),
    .LOCK_STABLE_CYCLES (ST_N),
    .MAX_RETRIES        (MAXR),
    .CNT_WIDTH          (16)
  ) dut (
    .REFERENCECLK   (clk),
    .RESET          (rst_n),
    .PLL_LOCK       (lock_r),
    .SOFT_RESTART   (soft_r),
    .PLL_RESETB     (pll_resetb),
    .CORE_RESETN    (core_resetn),
    .READY          (ready),
    .FAULT          (fault),
    .RETRY_COUNT    (retry_count),
    .LOCK_LOSS_COUNT(loss_count)
  );

  assign dut_vec = {pll_resetb, core_resetn, ready, fault, retry_count, loss_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pack(bit p, bit c, bit r, bit f, int rt, int ls);
    logic [1:0] rt2;
    logic [7:0] ls8;
    rt2 = rt[1:0];
    ls8 = ls[7:0];
    return {p, c, r, f, rt2, ls8};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each phase is left after a number of edges spent in it;
  // lock as seen by the sequencer is the input sampled two edges earlier.
  typedef enum int {P_HOLD, P_WAIT, P_STABLE, P_RUN, P_FAULT} phase_t;
  phase_t ph;
  int     k, ke, m_rty, m_loss;
  bit     samp[$];

  task automatic model_reset();
    ph = P_HOLD; k = 0; ke = 0; m_rty = 0; m_loss = 0;
    samp.delete();
  endtask

  task automatic model_edge(input bit lk, input bit sf);
    bit     ls;
    int     dwell;
    phase_t nx;
    k++;
    ls = (samp.size() >= 2) ? samp[samp.size()-2] : 1'b0;
    samp.push_back(lk);
    if (samp.size() > 4) void'(samp.pop_front());
    dwell = k - ke;
    nx = ph;
    if (sf) begin
      nx = P_HOLD; m_rty = 0; ke = k;
    end else begin
      case (ph)
        P_HOLD:   if (dwell == HOLD_N) nx = P_WAIT;
        P_WAIT:   if (ls) nx = P_STABLE;
                  else if (dwell == TO_N) begin
                    if (m_rty < MAXR) begin m_rty++; nx = P_HOLD; end
                    else nx = P_FAULT;
                  end
        P_STABLE: if (!ls) nx = P_WAIT; else if (dwell == ST_N) nx = P_RUN;
        P_RUN:    if (!ls) begin
                    nx = P_HOLD; m_rty = 0;
                    if (m_loss < 255) m_loss++;
                  end
        default:  nx = ph;
      endcase
      if (nx != ph) ke = k;
    end
    ph = nx;
  endtask

  function automatic logic [13:0] model_vec();
    return pack(ph == P_WAIT || ph == P_STABLE || ph == P_RUN, ph == P_RUN, ph == P_RUN,
                ph == P_FAULT, m_rty, m_loss);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(lock_r, soft_r);
    @(negedge clk);
    check("model", dut_vec, model_vec());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_values", dut_vec, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // which: 0 = READY, 1 = FAULT; took = ticks needed, -1 if bound expired
  task automatic wait_for(input int which, input int bound, output int took);
    took = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if ((which == 0 && ready) || (which == 1 && fault)) begin
        took = i;
        break;
      end
    end
  endtask

  typedef struct {
    int n; bit rst; bit lock;
    bit pll; bit core; bit rdy; bit flt; int rty; int loss;
  } row_t;
  row_t rows[15];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (rows[i].rst) do_reset();
      lock_r = rows[i].lock;
      soft_r = 1'b0;
      for (int j = 0; j < rows[i].n; j++) tick();
      check($sformatf("row%0d", i), dut_vec,
            pack(rows[i].pll, rows[i].core, rows[i].rdy, rows[i].flt, rows[i].rty, rows[i].loss));
    end
  endtask

  initial begin
    int took;
    rst_n = 1'b0; lock_r = 1'b0; soft_r = 1'b0;
    model_reset();
    //           n  rst lk pll cor rdy flt rty loss
    rows[0]  = '{0,  1, 0, 0,  0,  0,  0,  0,  0};
    rows[1]  = '{3,  0, 0, 0,  0,  0,  0,  0,  0};
    rows[2]  = '{1,  0, 0, 1,  0,  0,  0,  0,  0};
    rows[3]  = '{6,  0, 0, 1,  0,  0,  0,  0,  0};
    rows[4]  = '{9,  0, 1, 1,  0,  0,  0,  0,  0};
    rows[5]  = '{1,  0, 1, 1,  0,  0,  0,  0,  0};
    rows[6]  = '{1,  0, 1, 1,  1,  1,  0,  0,  0};
    rows[7]  = '{0,  1, 0, 0,  0,  0,  0,  0,  0};
    rows[8]  = '{23, 0, 0, 1,  0,  0,  0,  0,  0};
    rows[9]  = '{1,  0, 0, 0,  0,  0,  0,  1,  0};
    rows[10] = '{23, 0, 0, 1,  0,  0,  0,  1,  0};
    rows[11] = '{1,  0, 0, 0,  0,  0,  0,  2,  0};
    rows[12] = '{23, 0, 0, 1,  0,  0,  0,  2,  0};
    rows[13] = '{1,  0, 0, 0,  0,  0,  1,  2,  0};
    rows[14] = '{50, 0, 0, 0,  0,  0,  1,  2,  0};

    repeat (2) @(negedge clk);

    // Power-up sequence with lock arriving 10 cycles after release
    run_rows(0, 6);

    // Single-cycle lock drop while qualifying
    do_reset();
    lock_r = 1'b0;
    repeat (10) tick();
    lock_r = 1'b1;
    repeat (3) tick();
    repeat (2) tick();
    lock_r = 1'b0;
    tick();
    lock_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_core_low", core_resetn, 0);
    end
    tick();
    check("glitch_run", {core_resetn, ready, retry_count}, 4'b1100);

    // No lock: retries then fault
    run_rows(7, 14);

    // Back to RUN via restart, then repeated lock losses
    soft_r = 1'b1; lock_r = 1'b1;
    tick();
    soft_r = 1'b0;
    check("fault_cleared", {fault, pll_resetb, retry_count}, 0);
    wait_for(0, 60, took);
    check("reach_run", ready, 1);
    for (int i = 0; i < 260; i++) begin
      lock_r = 1'b0;
      tick();
      tick();
      check("loss_still_ready", ready, 1);
      tick();
      check("loss_outputs", {core_resetn, ready, pll_resetb}, 0);
      check("loss_count", loss_count, (i + 1 > 255) ? 255 : i + 1);
      lock_r = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        check("loss_pll_hold", pll_resetb, 0);
      end
      tick();
      check("loss_pll_release", pll_resetb, 1);
      wait_for(0, 40, took);
      check("relock_latency", took, 9);
    end

    // Restart exactly on the final timeout edge, then restart out of FAULT
    lock_r = 1'b0; soft_r = 1'b1;
    tick();
    soft_r = 1'b0;
    check("sr_from_run", {core_resetn, pll_resetb, retry_count}, 0);
    repeat (71) tick();
    check("sr_pre_timeout", {retry_count, fault}, 3'b100);
    soft_r = 1'b1;
    tick();
    soft_r = 1'b0;
    check("sr_timeout_edge", {fault, pll_resetb, retry_count}, 0);
    check("sr_keeps_loss", loss_count, 255);
    wait_for(1, 100, took);
    check("fault_latency", took, 72);
    soft_r = 1'b1;
    tick();
    soft_r = 1'b0;
    check("sr_in_fault", {fault, pll_resetb, retry_count}, 0);
    repeat (3) tick();
    check("sr_hold", pll_resetb, 0);
    tick();
    check("sr_hold_done", pll_resetb, 1);

    // Asynchronous reset in the middle of RUN
    lock_r = 1'b1;
    wait_for(0, 60, took);
    check("reach_run2", ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(1, 6);

    // Random lock activity and restarts
    do_reset();
    lock_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) lock_r = ~lock_r;
      soft_r = ($urandom_range(0, 149) == 0);
      tick();
    end
    soft_r = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
